// File: rtl/conv1d_pkg.sv
// Shared command codes, FSM encoding and default sizes for the lane-parallel conv1d engine.
package conv1d_pkg;

    localparam int DATA_W_DEF         = 8;
    localparam int ACC_W_DEF          = 32;
    localparam int MAX_INPUT_SIZE_DEF = 1024;
    localparam int MAX_CHANNELS_DEF   = 128;
    localparam int KERNEL_LENGTH_DEF  = 8;
    localparam int LANES_DEF          = 4;

    localparam logic [6:0] CMD_RESET  = 7'd0;
    localparam logic [6:0] CMD_WR_IN  = 7'd10;
    localparam logic [6:0] CMD_WR_KER = 7'd11;
    localparam logic [6:0] CMD_RD_IN  = 7'd13;
    localparam logic [6:0] CMD_RD_KER = 7'd14;
    localparam logic [6:0] CMD_OFFSET = 7'd20;
    localparam logic [6:0] CMD_WIDTH  = 7'd25;
    localparam logic [6:0] CMD_DEPTH  = 7'd26;
    localparam logic [6:0] CMD_BIAS   = 7'd27;
    localparam logic [6:0] CMD_START  = 7'd41;
    localparam logic [6:0] CMD_ORIGIN = 7'd42;
    localparam logic [6:0] CMD_RD_ACC = 7'd43;
    localparam logic [6:0] CMD_STATUS = 7'd44;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv1d_mac_lanes.sv
// Combinational LANES-wide masked (x+offset)*w multiply with adder reduction; zero latency.
// No flow control: the engine samples sum_dat every RUN cycle.
module conv1d_mac_lanes #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int LANES  = 4
) (
    input  logic [LANES-1:0][DATA_W-1:0] x_dat,
    input  logic [LANES-1:0][DATA_W-1:0] w_dat,
    input  logic [LANES-1:0]             lane_en,
    input  logic [DATA_W:0]              offset,
    output logic [ACC_W-1:0]             sum_dat
);

    logic [LANES-1:0][ACC_W-1:0] prod;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DATA_W:0]  x_off;
        logic [ACC_W-1:0] x_ext;
        logic [ACC_W-1:0] w_ext;

        // Offset add wraps in DATA_W+1 bits; the ACC_W-wide product equals the signed product mod 2^ACC_W.
        assign x_off   = {x_dat[l][DATA_W-1], x_dat[l]} + offset;
        assign x_ext   = {{(ACC_W-DATA_W-1){x_off[DATA_W]}}, x_off};
        assign w_ext   = {{(ACC_W-DATA_W){w_dat[l][DATA_W-1]}}, w_dat[l]};
        assign prod[l] = lane_en[l] ? x_ext * w_ext : '0;
    end

    always_comb begin
        sum_dat = '0;
        for (int l = 0; l < LANES; l++) begin
            sum_dat = sum_dat + prod[l];
        end
    end

endmodule

// File: rtl/conv1d_lane_engine.sv
// Command-driven conv1d CFU: one output point in KERNEL_LENGTH*ceil(depth/LANES)+1 cycles after start.
// CPU polls output_buffer_valid; config writes and starts are dropped while busy. CONV1D_BIAS_EN adds a bias register.
module conv1d_lane_engine
    import conv1d_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int ACC_W          = ACC_W_DEF,
    parameter int MAX_INPUT_SIZE = MAX_INPUT_SIZE_DEF,
    parameter int MAX_CHANNELS   = MAX_CHANNELS_DEF,
    parameter int KERNEL_LENGTH  = KERNEL_LENGTH_DEF,
    parameter int LANES          = LANES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [6:0]       cmd,
    input  logic [ACC_W-1:0] inp0,
    input  logic [ACC_W-1:0] inp1,
    output logic [ACC_W-1:0] ret,
    output logic             output_buffer_valid
);

    localparam int IN_SIZE  = MAX_INPUT_SIZE * MAX_CHANNELS;
    localparam int KER_SIZE = KERNEL_LENGTH * MAX_CHANNELS;
    localparam int IN_AW    = $clog2(IN_SIZE);
    localparam int KER_AW   = $clog2(KER_SIZE);
    localparam int TAP_W    = $clog2(KERNEL_LENGTH);
    localparam int GRP_W    = $clog2(MAX_CHANNELS / LANES) + 1;

    logic [DATA_W-1:0] in_buf  [IN_SIZE];
    logic [DATA_W-1:0] ker_buf [KER_SIZE];

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W:0]   offset_q, offset_d;
    logic [ACC_W-1:0]  width_q, width_d;
    logic [ACC_W-1:0]  depth_q, depth_d;
    logic [ACC_W-1:0]  origin_q, origin_d;
    logic [ACC_W-1:0]  ret_q, ret_d;
    logic [TAP_W-1:0]  tap_q, tap_d;
    logic [GRP_W-1:0]  grp_q, grp_d;
    logic [GRP_W-1:0]  ngrp_q, ngrp_d;

    logic              busy;
    logic              cfg_wr;
    logic              start;
    logic              depth_ok;
    logic              grp_last;
    logic              last_step;
    logic [ACC_W-1:0]  bias_val;
    logic [ACC_W-1:0]  in_x;
    logic              x_ok;
    logic [ACC_W-1:0]  ch     [LANES];
    logic [IN_AW-1:0]  x_idx  [LANES];
    logic [KER_AW-1:0] k_idx  [LANES];
    logic [LANES-1:0]  lane_en;
    logic [LANES-1:0][DATA_W-1:0] lane_x;
    logic [LANES-1:0][DATA_W-1:0] lane_w;
    logic [ACC_W-1:0]  lane_sum;
    logic [DATA_W-1:0] rd_in_raw;
    logic [DATA_W-1:0] rd_ker_raw;

    assign cfg_wr    = en && !busy;
    assign start     = cfg_wr && (cmd == CMD_START);
    assign depth_ok  = (depth_q != '0) && (depth_q <= ACC_W'(MAX_CHANNELS));
    assign grp_last  = (grp_q == ngrp_q - GRP_W'(1));
    assign last_step = grp_last && (tap_q == TAP_W'(KERNEL_LENGTH - 1));

`ifdef CONV1D_BIAS_EN
    logic [ACC_W-1:0] bias_q, bias_d;

    always_comb begin
        bias_d = bias_q;
        if (cfg_wr && cmd == CMD_RESET) bias_d = '0;
        if (cfg_wr && cmd == CMD_BIAS)  bias_d = inp1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bias_q <= '0;
        else     bias_q <= bias_d;
    end

    assign bias_val = bias_q;
`else
    assign bias_val = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = depth_ok ? RUN : DONE;
            RUN:     if (last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy                = (state_q != IDLE);
        output_buffer_valid = !busy;
    end

    // Lane l of group g covers channel g*LANES+l at spatial position origin+tap.
    always_comb begin
        in_x = origin_q + ACC_W'(tap_q);
        x_ok = !in_x[ACC_W-1] && (in_x < width_q);
        for (int l = 0; l < LANES; l++) begin
            ch[l]      = ACC_W'(grp_q) * ACC_W'(LANES) + ACC_W'(l);
            x_idx[l]   = IN_AW'(in_x * depth_q + ch[l]);
            k_idx[l]   = KER_AW'(ACC_W'(tap_q) * depth_q + ch[l]);
            lane_en[l] = (state_q == RUN) && x_ok && (ch[l] < depth_q);
            lane_x[l]  = lane_en[l] ? in_buf[x_idx[l]] : '0;
            lane_w[l]  = lane_en[l] ? ker_buf[k_idx[l]] : '0;
        end
    end

    conv1d_mac_lanes #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .LANES  (LANES)
    ) u_mac (
        .x_dat   (lane_x),
        .w_dat   (lane_w),
        .lane_en (lane_en),
        .offset  (offset_q),
        .sum_dat (lane_sum)
    );

    assign rd_in_raw  = (inp0 < ACC_W'(IN_SIZE))  ? in_buf[IN_AW'(inp0)]   : '0;
    assign rd_ker_raw = (inp0 < ACC_W'(KER_SIZE)) ? ker_buf[KER_AW'(inp0)] : '0;

    always_comb begin
        acc_d    = acc_q;
        offset_d = offset_q;
        width_d  = width_q;
        depth_d  = depth_q;
        origin_d = origin_q;
        ret_d    = ret_q;
        tap_d    = tap_q;
        grp_d    = grp_q;
        ngrp_d   = ngrp_q;

        if (state_q == RUN) begin
            acc_d = acc_q + lane_sum;
            if (grp_last) begin
                grp_d = '0;
                tap_d = tap_q + TAP_W'(1);
            end else begin
                grp_d = grp_q + GRP_W'(1);
            end
        end

        if (cfg_wr) begin
            case (cmd)
                CMD_RESET: begin
                    acc_d    = '0;
                    offset_d = '0;
                    width_d  = '0;
                    depth_d  = '0;
                    origin_d = '0;
                    ret_d    = '0;
                end
                CMD_OFFSET: offset_d = inp1[DATA_W:0];
                CMD_WIDTH:  width_d  = (inp1 > ACC_W'(MAX_INPUT_SIZE)) ? ACC_W'(MAX_INPUT_SIZE) : inp1;
                CMD_DEPTH:  depth_d  = inp1;
                CMD_ORIGIN: origin_d = inp1;
                CMD_START: begin
                    acc_d  = bias_val;
                    tap_d  = '0;
                    grp_d  = '0;
                    ngrp_d = GRP_W'((depth_q + ACC_W'(LANES - 1)) / ACC_W'(LANES));
                end
                default: ;
            endcase
        end

        if (en) begin
            case (cmd)
                CMD_RD_IN:  ret_d = {{(ACC_W-DATA_W){rd_in_raw[DATA_W-1]}}, rd_in_raw};
                CMD_RD_KER: ret_d = {{(ACC_W-DATA_W){rd_ker_raw[DATA_W-1]}}, rd_ker_raw};
                CMD_RD_ACC: ret_d = acc_q;
                CMD_STATUS: ret_d = {{(ACC_W-1){1'b0}}, busy};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            offset_q <= '0;
            width_q  <= '0;
            depth_q  <= '0;
            origin_q <= '0;
            ret_q    <= '0;
            tap_q    <= '0;
            grp_q    <= '0;
            ngrp_q   <= '0;
        end else begin
            acc_q    <= acc_d;
            offset_q <= offset_d;
            width_q  <= width_d;
            depth_q  <= depth_d;
            origin_q <= origin_d;
            ret_q    <= ret_d;
            tap_q    <= tap_d;
            grp_q    <= grp_d;
            ngrp_q   <= ngrp_d;
        end
    end

    // Sample buffers hold data across reset.
    always_ff @(posedge clk) begin
        if (cfg_wr && cmd == CMD_WR_IN && inp0 < ACC_W'(IN_SIZE))
            in_buf[IN_AW'(inp0)] <= inp1[DATA_W-1:0];
        if (cfg_wr && cmd == CMD_WR_KER && inp0 < ACC_W'(KER_SIZE))
            ker_buf[KER_AW'(inp0)] <= inp1[DATA_W-1:0];
    end

    assign ret = ret_q;

endmodule

// File: tb/tb_conv1d_lane_engine.sv
// Scoreboard bench for conv1d_lane_engine: stimulus queues expected ret values and start latencies,
// a negedge monitor pops and compares them as the DUT presents reads and completions.
module tb_conv1d_lane_engine;
    import conv1d_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [6:0]  cmd = '0;
    logic [31:0] inp0 = '0;
    logic [31:0] inp1 = '0;
    logic [31:0] ret;
    logic        output_buffer_valid;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];

    bit mon_rd  = 1'b0;
    bit mon_trk = 1'b0;
    int mon_cnt = 0;

    always #5 clk = ~clk;

    conv1d_lane_engine dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .cmd                 (cmd),
        .inp0                (inp0),
        .inp1                (inp1),
        .ret                 (ret),
        .output_buffer_valid (output_buffer_valid)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, exp, exp);
        end
    endtask

    task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] v);
        en = 1'b1; cmd = c; inp0 = a; inp1 = v;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic rd(input logic [6:0] c, input logic [31:0] a, input logic [31:0] e);
        exp_q.push_back(e);
        issue(c, a, 32'd0);
    endtask

    task automatic start_run(input int lat);
        if (lat > 0) lat_q.push_back(lat);
        issue(CMD_START, 32'd0, 32'd0);
    endtask

    task automatic cfg(input int d, input int w, input int o, input int off);
        issue(CMD_DEPTH,  32'(d),   32'(d));
        issue(CMD_DEPTH,  32'd0,    32'(d));
        issue(CMD_WIDTH,  32'd0,    32'(w));
        issue(CMD_ORIGIN, 32'd0,    32'(o));
        issue(CMD_OFFSET, 32'd0,    32'(off));
    endtask

    task automatic fill(input logic [6:0] c, input int base, input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) issue(c, 32'(base + i), {24'd0, v});
    endtask

    task automatic wait_idle;
        int n = 0;
        while (!output_buffer_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!output_buffer_valid) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: output_buffer_valid still %0b after %0d cycles, expected 1", output_buffer_valid, n);
        end
    endtask

    // Monitor: a read sampled at an edge is checked at the following negedge;
    // a tracked start counts low-valid negedges until completion.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_rd  = 1'b0;
                mon_trk = 1'b0;
            end else begin
                if (mon_rd) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL ret_unexpected: got 0x%08h, no expected value queued", ret);
                    end else begin
                        chk("ret", ret, exp_q.pop_front());
                    end
                end
                if (mon_trk) begin
                    if (output_buffer_valid) begin
                        chk("latency", 32'(mon_cnt), 32'(lat_q.pop_front()));
                        mon_trk = 1'b0;
                    end else begin
                        mon_cnt++;
                    end
                end
                mon_rd = en && (cmd == CMD_RD_IN || cmd == CMD_RD_KER ||
                                cmd == CMD_RD_ACC || cmd == CMD_STATUS);
                if (en && cmd == CMD_START && output_buffer_valid && !mon_trk && lat_q.size() > 0) begin
                    mon_trk = 1'b1;
                    mon_cnt = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bias_exp;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("reset_valid", {31'd0, output_buffer_valid}, 32'd1);
        rd(CMD_RD_ACC, 32'd0, 32'd0);
        rd(CMD_STATUS, 32'd0, 32'd0);

        // Reset during a long run aborts to idle with acc cleared
        cfg(128, 8, 0, 0);
        start_run(0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk("rst_abort_valid", {31'd0, output_buffer_valid}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        rd(CMD_RD_ACC, 32'd0, 32'd0);
        rd(CMD_STATUS, 32'd0, 32'd0);

        // Basic: depth 1, x=1, w=2 over 8 taps
        fill(CMD_WR_IN, 0, 8, 8'd1);
        fill(CMD_WR_KER, 0, 8, 8'd2);
        cfg(1, 8, 0, 0);
        start_run(9);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd16);

        // Busy protection: ignored depth write and restart, status and partial acc while running
        start_run(9);
        issue(CMD_DEPTH, 32'd0, 32'd7);
        issue(CMD_START, 32'd0, 32'd0);
        rd(CMD_STATUS, 32'd0, 32'd1);
        rd(CMD_RD_ACC, 32'd0, 32'd6);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd16);
        rd(CMD_STATUS, 32'd0, 32'd0);
        start_run(9);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd16);

        // Bias register
`ifdef CONV1D_BIAS_EN
        bias_exp = 32'd6;
`else
        bias_exp = 32'd16;
`endif
        issue(CMD_BIAS, 32'd0, 32'hFFFF_FFF6);
        start_run(9);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, bias_exp);
        issue(CMD_RESET, 32'd0, 32'd0);
        rd(CMD_RD_ACC, 32'd0, 32'd0);

        // Zero padding with negative origin and input offset
        fill(CMD_WR_IN, 0, 16, 8'd3);
        fill(CMD_WR_KER, 0, 16, 8'd1);
        cfg(2, 8, -4, 1);
        start_run(9);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd32);

        // Partial last lane group; garbage past the used range must be masked
        fill(CMD_WR_IN, 0, 40, 8'h80);
        fill(CMD_WR_IN, 40, 8, 8'h7F);
        fill(CMD_WR_KER, 0, 40, 8'h80);
        fill(CMD_WR_KER, 40, 8, 8'h7F);
        cfg(5, 8, 0, 0);
        start_run(17);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd655360);

        // Buffer readback with sign extension and out-of-range addresses
        rd(CMD_RD_KER, 32'd0, 32'hFFFF_FF80);
        rd(CMD_RD_IN, 32'd40, 32'h0000_007F);
        issue(CMD_WR_IN, 32'd131072, 32'd5);
        rd(CMD_RD_IN, 32'd131072, 32'd0);
        rd(CMD_RD_KER, 32'd1024, 32'd0);

        // depth 0 and depth > MAX_CHANNELS skip RUN
        cfg(0, 8, 0, 0);
        start_run(1);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd0);
        fill(CMD_WR_IN, 0, 8, 8'd1);
        fill(CMD_WR_KER, 0, 8, 8'd2);
        cfg(1, 8, 0, 0);
        start_run(9);
        wait_idle();
        cfg(200, 8, 0, 0);
        start_run(1);
        wait_idle();
        rd(CMD_RD_ACC, 32'd0, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0 || lat_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL leftover: %0d reads and %0d latencies never observed, expected 0", exp_q.size(), lat_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
